// File: rtl/mem_arbiter_rr_pkg.sv
// Shared arbiter types: FSM encoding, requester IDs and round-robin helpers.
// Pure declarations; no timing, no backpressure.
package mem_arbiter_rr_pkg;

    localparam int NUM_REQ      = 3;
    localparam int MAX_HOLD_DEF = 4;
    localparam int CNT_W_DEF    = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        ID_ROM    = 2'd0,
        ID_RAM_RD = 2'd1,
        ID_RAM_WR = 2'd2
    } req_id_e;

    // Rotation order ROM -> RAM_RD -> RAM_WR -> ROM.
    function automatic req_id_e rr_next(input req_id_e id);
        case (id)
            ID_ROM:    return ID_RAM_RD;
            ID_RAM_RD: return ID_RAM_WR;
            default:   return ID_ROM;
        endcase
    endfunction

    function automatic logic [NUM_REQ-1:0] id_onehot(input req_id_e id);
        case (id)
            ID_ROM:    return 3'b001;
            ID_RAM_RD: return 3'b010;
            ID_RAM_WR: return 3'b100;
            default:   return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_rr_pick.sv
// Combinational round-robin picker: first requester after last_id wins, last_id itself lowest.
// Zero latency; no backpressure, win_vld low when nothing is requesting.
module rr_pick
    import mem_arbiter_rr_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_vec,
    input  req_id_e            last_id,
    output req_id_e            win_id,
    output logic               win_vld
);

    req_id_e cand1;
    req_id_e cand2;

    assign cand1 = rr_next(last_id);
    assign cand2 = rr_next(cand1);

    always_comb begin
        win_id  = cand1;
        win_vld = 1'b1;
        if (|(req_vec & id_onehot(cand1))) begin
            win_id = cand1;
        end else if (|(req_vec & id_onehot(cand2))) begin
            win_id = cand2;
        end else if (|(req_vec & id_onehot(last_id))) begin
            win_id = last_id;
        end else begin
            win_vld = 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// Three-way round-robin memory bus arbiter with hold limit and one-cycle turnaround; grants are registered (1 cycle after request).
// Losing or waiting requesters see their pause output combinationally in the same cycle.
module mem_arbiter_rr
    import mem_arbiter_rr_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic rom_rd,
    input  logic ram_rd,
    input  logic ram_wr,
    output logic rom_garant,
    output logic ram_garant_rd,
    output logic ram_garant_wr,
    output logic pause_READ,
    output logic pause_DECODE,
    output logic pause_WRITE,
    output logic busy
);

    if (MAX_HOLD < 1 || (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_param
        $error("mem_arbiter_rr: need MAX_HOLD >= 1 and 2**CNT_W > MAX_HOLD");
    end

    localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_e          state_q,    state_d;
    logic [NUM_REQ-1:0]  grant_q,    grant_d;
    req_id_e             last_q,     last_d;
    logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;

    logic [NUM_REQ-1:0]  req_vec;
    logic [NUM_REQ-1:0]  owner_mask;
    logic                owner_req;
    logic                others_req;
    req_id_e             pick_id;
    logic                pick_vld;

    assign req_vec    = {ram_wr, ram_rd, rom_rd};
    assign owner_mask = id_onehot(last_q);
    assign owner_req  = |(req_vec & owner_mask);
    assign others_req = |(req_vec & ~owner_mask);

    rr_pick u_rr_pick (
        .req_vec (req_vec),
        .last_id (last_q),
        .win_id  (pick_id),
        .win_vld (pick_vld)
    );

    // In GRANT the last-owner pointer is the current owner; hold_cnt counts
    // cycles already held before the current one.
    always_comb begin
        state_d    = state_q;
        grant_d    = '0;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_GRANT: begin
                if (!owner_req) begin
                    state_d = others_req ? ST_TURN : ST_IDLE;
                end else if (others_req && hold_cnt_q >= HOLD_LAST) begin
                    state_d = ST_TURN;
                end else begin
                    grant_d    = grant_q;
                    hold_cnt_d = (hold_cnt_q == HOLD_SAT) ? hold_cnt_q
                                                          : hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                // IDLE and TURN both hand the bus to the picker's winner.
                if (pick_vld) begin
                    state_d    = ST_GRANT;
                    grant_d    = id_onehot(pick_id);
                    last_d     = pick_id;
                    hold_cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            last_q     <= ID_RAM_WR;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign rom_garant    = grant_q[0];
    assign ram_garant_rd = grant_q[1];
    assign ram_garant_wr = grant_q[2];

    assign pause_READ   = rom_rd & ~rom_garant;
    assign pause_DECODE = ram_rd & ~ram_garant_rd;
    assign pause_WRITE  = ram_wr & ~ram_garant_wr;

    assign busy = (|grant_q) | (state_q == ST_TURN);

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Scoreboard bench for mem_arbiter_rr: reference model pushes expected grants, checked after each edge.
module tb_mem_arbiter_rr;

    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rom_rd = 1'b0;
    logic ram_rd = 1'b0;
    logic ram_wr = 1'b0;
    logic rom_garant, ram_garant_rd, ram_garant_wr;
    logic pause_READ, pause_DECODE, pause_WRITE;
    logic busy;
    logic [2:0] dut_grant;

    typedef struct packed {
        logic [2:0] grant;
        logic       busy;
    } exp_t;

    exp_t       exp_q[$];
    logic [2:0] trace_q[$];
    logic [2:0] seq_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: 0 idle, 1 grant, 2 turn; m_held counts granted cycles incl. current
    int         m_state;
    int         m_owner;
    int         m_held;
    int         m_last;
    logic [2:0] m_grant;

    mem_arbiter_rr #(.MAX_HOLD(MAX_HOLD), .CNT_W(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .rom_rd        (rom_rd),
        .ram_rd        (ram_rd),
        .ram_wr        (ram_wr),
        .rom_garant    (rom_garant),
        .ram_garant_rd (ram_garant_rd),
        .ram_garant_wr (ram_garant_wr),
        .pause_READ    (pause_READ),
        .pause_DECODE  (pause_DECODE),
        .pause_WRITE   (pause_WRITE),
        .busy          (busy)
    );

    assign dut_grant = {ram_garant_wr, ram_garant_rd, rom_garant};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_state = 0;
        m_owner = 0;
        m_held  = 0;
        m_last  = 2;
        m_grant = 3'b000;
        exp_q.delete();
    endtask

    task automatic model_step(input logic [2:0] r);
        logic [2:0] oth;
        int         w;
        exp_t       e;
        w = -1;
        if (m_state != 1) begin
            for (int k = 1; k <= 3; k++)
                if (w < 0 && r[(m_last + k) % 3]) w = (m_last + k) % 3;
            if (w >= 0) begin
                m_state = 1; m_owner = w; m_last = w; m_held = 1;
                m_grant = 3'b001 << w;
            end else begin
                m_state = 0; m_grant = 3'b000;
            end
        end else begin
            oth = r & ~(3'b001 << m_owner);
            if (!r[m_owner]) begin
                m_state = (oth != 3'b000) ? 2 : 0;
                m_grant = 3'b000;
            end else if (m_held >= MAX_HOLD && oth != 3'b000) begin
                m_state = 2;
                m_grant = 3'b000;
            end else begin
                m_held++;
            end
        end
        e.grant = m_grant;
        e.busy  = (m_state != 0);
        exp_q.push_back(e);
    endtask

    // Called away from the rising edge; returns on the following falling edge.
    task automatic cycle(input logic [2:0] r);
        exp_t e;
        {ram_wr, ram_rd, rom_rd} = r;
        #1;
        check_eq("pause", {pause_WRITE, pause_DECODE, pause_READ}, r & ~m_grant);
        model_step(r);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq("sb_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq("grant", dut_grant, e.grant);
            check_eq("busy", busy, e.busy);
        end
        check_eq("onehot", $countones(dut_grant) <= 1, 1);
        trace_q.push_back(dut_grant);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [2:0] r);
        {ram_wr, ram_rd, rom_rd} = r;
        reset = 1'b0;
        model_reset();
        #1;
        check_eq("rst_grant", dut_grant, 3'b000);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_pause", {pause_WRITE, pause_DECODE, pause_READ}, r);
        @(posedge clk);
        #1;
        check_eq("rst_hold_grant", dut_grant, 3'b000);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("rel_grant", dut_grant, 3'b000);
    endtask

    task automatic check_trace(input string tag, input logic [2:0] exp_seq[$]);
        check_eq({tag, "_len"}, trace_q.size(), exp_seq.size());
        for (int i = 0; i < exp_seq.size() && i < trace_q.size(); i++)
            check_eq(tag, trace_q[i], exp_seq[i]);
    endtask

    initial begin
        model_reset();

        // reset with every request high, then ROM wins first
        do_reset(3'b111);
        trace_q.delete();
        cycle(3'b111);
        seq_q = '{3'b001};
        check_trace("first_rom", seq_q);
        cycle(3'b000);
        cycle(3'b000);

        // lone RAM write for ten cycles
        do_reset(3'b000);
        trace_q.delete();
        for (int i = 0; i < 10; i++) cycle(3'b100);
        cycle(3'b000);
        seq_q = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100,
                  3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000};
        check_trace("wr_alone", seq_q);
        cycle(3'b000);

        // ROM and RAM_RD both held: forced rotation every MAX_HOLD cycles
        do_reset(3'b000);
        trace_q.delete();
        for (int i = 0; i < 12; i++) cycle(3'b011);
        seq_q = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000,
                  3'b010, 3'b010, 3'b010, 3'b010, 3'b000,
                  3'b001, 3'b001};
        check_trace("rotate", seq_q);
        cycle(3'b000);
        cycle(3'b000);

        // owner RAM_RD drops while RAM_WR waits
        trace_q.delete();
        cycle(3'b010);
        cycle(3'b010);
        cycle(3'b100);
        cycle(3'b100);
        cycle(3'b000);
        seq_q = '{3'b010, 3'b010, 3'b000, 3'b100, 3'b000};
        check_trace("owner_drop", seq_q);

        // all three after RAM_RD was last owner
        cycle(3'b010);
        cycle(3'b000);
        cycle(3'b000);
        trace_q.delete();
        for (int i = 0; i < 14; i++) cycle(3'b111);
        seq_q = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b000,
                  3'b001, 3'b001, 3'b001, 3'b001, 3'b000,
                  3'b010, 3'b010, 3'b010, 3'b010};
        check_trace("all_three", seq_q);
        cycle(3'b000);
        cycle(3'b000);

        // asynchronous reset while RAM_WR owns the bus
        trace_q.delete();
        cycle(3'b100);
        cycle(3'b100);
        seq_q = '{3'b100, 3'b100};
        check_trace("wr_before_rst", seq_q);
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_grant", dut_grant, 3'b000);
        check_eq("async_busy", busy, 1'b0);
        do_reset(3'b111);
        trace_q.delete();
        cycle(3'b111);
        cycle(3'b111);
        seq_q = '{3'b001, 3'b001};
        check_trace("restart_rom", seq_q);
        cycle(3'b000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_rr.md
MEM_ARBITER_RR -- requirements
Module: mem_arbiter_rr

Interface
REQ-001 Parameter MAX_HOLD, default 4: maximum consecutive grant cycles one requester keeps while another requester is waiting.
REQ-002 Parameter CNT_W, default 3: hold-counter width; SHALL satisfy 2^CNT_W > MAX_HOLD.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rom_rd  input  1  fetch stage requests the shared memory bus (ROM read).
REQ-006 ram_rd  input  1  decode stage requests the shared memory bus (RAM read).
REQ-007 ram_wr  input  1  write stage requests the shared memory bus (RAM write).
REQ-008 rom_garant  output  1  ROM read granted; bus owned by fetch stage.
REQ-009 ram_garant_rd  output  1  RAM read granted.
REQ-010 ram_garant_wr  output  1  RAM write granted.
REQ-011 pause_READ / pause_DECODE / pause_WRITE  output  1 each  stall for the matching stage = its request high and its grant low.
REQ-012 busy  output  1  high while any grant is asserted or the arbiter is in TURN.

Function
REQ-013 Grants SHALL be registered outputs, one-hot or all-zero; never more than one grant high.
REQ-014 FSM states: IDLE (no grant), GRANT (one owner), TURN (one dead cycle, no grant, for shared addr_out bus turnaround).
REQ-015 IDLE: any request high -> GRANT to the winner on the next edge; grant visible one cycle after request first sampled.
REQ-016 Winner SHALL be chosen round-robin in order ROM -> RAM_RD -> RAM_WR -> ROM, starting at the requester after the last owner; after reset the search starts at ROM.
REQ-017 GRANT: owner request still high and (hold count < MAX_HOLD or no other request) -> stay; hold counter increments, saturating at MAX_HOLD.
REQ-018 GRANT: owner request low -> if another request pending go to TURN, else IDLE; grant drops on that edge.
REQ-019 GRANT: hold count = MAX_HOLD and another request pending -> TURN even if owner still requests (forced rotation).
REQ-020 TURN lasts exactly one cycle, then GRANT to the round-robin winner among requests sampled in TURN, or IDLE if none.
REQ-021 Re-grant to the same requester (sole requester returning from IDLE) SHALL NOT insert TURN.
REQ-022 Hold counter clears on every entry to GRANT; the last-owner pointer updates on every entry to GRANT.
REQ-023 Simultaneous requests in IDLE: only round-robin winner granted; others see pause high.
REQ-024 pause outputs are combinational from registered grants and live requests; a request with no grant SHALL assert its pause in the same cycle.

Reset
REQ-025 On reset low, asynchronously: state IDLE, all grants 0, hold counter 0, pointer = ROM first, busy 0; pause outputs then follow requests.
REQ-026 Reset asserted mid-grant SHALL drop the grant immediately; no grant in the first cycle after release.

Structure
REQ-027 Shared package holds FSM state encoding (IDLE/GRANT/TURN), requester IDs (ROM=0, RAM_RD=1, RAM_WR=2) and MAX_HOLD default.
REQ-028 One sub-module rr_pick: combinational round-robin picker, inputs 3-bit request vector and last-owner ID, outputs winner ID and valid.

Verification
REQ-029 Reset low with all requests high -> all grants 0, pause_* = 1; release reset -> rom_garant = 1 one cycle later.
REQ-030 ram_wr alone for 10 cycles -> ram_garant_wr high cycles 2-11, no TURN, pause_WRITE only in cycle 1.
REQ-031 rom_rd and ram_rd held high continuously, MAX_HOLD=4 -> ROM 4 cycles, 1 TURN, RAM_RD 4 cycles, 1 TURN, repeating.
REQ-032 Owner ram_rd drops while ram_wr pending -> grant low next cycle, one TURN, then ram_garant_wr.
REQ-033 All three requests in IDLE after last owner RAM_RD -> order RAM_WR, ROM, RAM_RD.
REQ-034 Reset pulsed during ram_garant_wr -> grant 0 asynchronously, FSM IDLE, pointer restarts at ROM.
